float_mul_dispatch: RTL and testbench
=====================================

FLOAT_MUL_DISPATCH -- requirements
Module: float_mul_dispatch

Interface
REQ-001 SHALL have parameter float_width, default 32, operand/result width.
REQ-002 SHALL have parameter tag_width, default 4, request tag width.
REQ-003 SHALL have parameter fifo_depth, default 4, operand queue entries (power of two, >=2).
REQ-004 SHALL have parameter timeout_cycles, default 64, maximum cycles waited for mul_ack.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  input  1  clock; all state updates on posedge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream operand pair valid.
REQ-009 in_ready  output  1  queue can accept a pair (!full).
REQ-010 in_a, in_b  input  float_width  operands.
REQ-011 in_tag  input  tag_width  request identifier.
REQ-012 mul_req  output  1  one-cycle request pulse to the multiplier.
REQ-013 mul_a, mul_b  output  float_width  operands to the multiplier, registered.
REQ-014 mul_ack  input  1  multiplier result strobe, single cycle.
REQ-015 mul_out  input  float_width  multiplier result, valid when mul_ack=1.
REQ-016 res_valid  output  1  result slot full.
REQ-017 res_ready  input  1  downstream accepts result.
REQ-018 res_out  output  float_width  product; res_tag output tag_width matching tag.
REQ-019 busy  output  1  state!=IDLE; err  output  1  sticky timeout flag.

Function
REQ-020 Push SHALL occur on in_valid&&in_ready; in_valid while full SHALL be ignored, with no queue change.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo fifo_depth.
REQ-022 The FSM SHALL have states IDLE, WAIT, and DONE, encoded as a 2-bit register.
REQ-023 IDLE->WAIT SHALL occur when the queue is non-empty and res_valid=0; on that transition, mul_a, mul_b, and the tag SHALL be loaded from the queue head.
REQ-024 mul_req SHALL be 1 exactly in the first WAIT cycle and 0 otherwise; mul_a and mul_b SHALL stay stable from that cycle until the transition out of WAIT.
REQ-025 In WAIT, mul_ack=1 (including in the first WAIT cycle) SHALL capture mul_out into res_out, pop the head, and transition to DONE.
REQ-026 In WAIT, a 7-bit-or-wider cycle counter SHALL increment each cycle and reset on WAIT entry.
REQ-027 On reaching timeout_cycles without ack: err:=1, res_out:='0, pop the head, and transition to DONE.
REQ-028 DONE SHALL set res_valid=1 and res_tag=the issued tag, then transition to IDLE on the next cycle.
REQ-029 res_valid SHALL clear on res_valid&&res_ready, and res_out and res_tag SHALL hold until then.
REQ-030 mul_ack in IDLE or DONE SHALL be ignored (late or spurious) and SHALL NOT change any state or err.
REQ-031 Latency: pair accepted at edge T; mul_req high in cycle T+2 at earliest; ack in cycle A gives res_valid=1 in cycle A+2.
REQ-032 Results SHALL be returned in acceptance order, with one multiply outstanding at most.
REQ-033 err SHALL clear only on rst.

Reset
REQ-034 With rst=1 at an edge: state=IDLE; queue empty (pointers and count 0); mul_req=0; mul_a=mul_b='0; res_valid=0; res_out='0; res_tag='0; err=0; busy=0; in_ready=1 from the following cycle.
REQ-035 Reset mid-WAIT SHALL abandon the in-flight request, and a subsequent mul_ack SHALL be ignored per REQ-030.

Verification
REQ-036 Single op: push a=0x40000000, b=0x40400000, tag=3; model ack 3 cycles after mul_req with mul_out=0x40C00000 -> one mul_req pulse, then res_out=0x40C00000, res_tag=3, res_valid held until res_ready.
REQ-037 Fill: push 5 pairs back-to-back with res_ready=0 and no ack -> in_ready=0 after 4 pushes; 5th ignored; count=4.
REQ-038 Ordering: tags 1,2,3,4 with ack latencies 1,5,2,7 and res_ready=1 -> results returned with tags 1,2,3,4, and mul_req never high while in WAIT beyond the first cycle.
REQ-039 Timeout: no ack for 64 cycles -> err=1, res_out=0 with correct tag; a later late ack is ignored; the next queued op completes normally.
REQ-040 Back-pressure: res_ready=0 with 2 queued -> second mul_req not issued until first result drained.
REQ-041 Reset mid-WAIT then stray ack -> all outputs at reset values, no res_valid.

Source files
------------

// File: rtl/float_mul_dispatch.sv
// Queues floating-point operand pairs and dispatches them one at a time to an
// external multiplier, returning tagged products in order with a per-request timeout.
module float_mul_dispatch #(
    parameter int float_width    = 32,
    parameter int tag_width      = 4,
    parameter int fifo_depth     = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] in_a,
    input  logic [float_width-1:0] in_b,
    input  logic [tag_width-1:0]   in_tag,
    output logic                   mul_req,
    output logic [float_width-1:0] mul_a,
    output logic [float_width-1:0] mul_b,
    input  logic                   mul_ack,
    input  logic [float_width-1:0] mul_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [float_width-1:0] res_out,
    output logic [tag_width-1:0]   res_tag,
    output logic                   busy,
    output logic                   err
);
    localparam int ptr_w = $clog2(fifo_depth);
    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam int tmo_w = ($clog2(timeout_cycles + 1) > 7) ? $clog2(timeout_cycles + 1) : 7;
    localparam logic [cnt_w-1:0] depth_c    = cnt_w'(fifo_depth);
    localparam logic [tmo_w-1:0] tmo_last_c = tmo_w'(timeout_cycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [float_width-1:0] mem_a_r   [fifo_depth];
    logic [float_width-1:0] mem_b_r   [fifo_depth];
    logic [tag_width-1:0]   mem_tag_r [fifo_depth];
    logic [ptr_w-1:0]       wr_ptr_r;
    logic [ptr_w-1:0]       rd_ptr_r;
    logic [cnt_w-1:0]       count_r;
    logic [cnt_w-1:0]       count_nxt_s;
    logic [tmo_w-1:0]       tmo_cnt_r;
    logic [tag_width-1:0]   tag_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   issue_s;
    logic                   timeout_s;
    logic                   empty_s;

    // in_ready is a registered copy of !full, so it is exact for the current count
    assign push_s  = in_valid && in_ready;
    assign empty_s = (count_r == cnt_w'(0));

    // Next-state and dispatch/retire decisions
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        pop_s       = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && !res_valid) begin
                    state_nxt_s = WAIT;
                    issue_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (mul_ack) begin
                    state_nxt_s = DONE;
                    pop_s       = 1'b1;
                end else if (tmo_cnt_r == tmo_last_c) begin
                    state_nxt_s = DONE;
                    pop_s       = 1'b1;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + cnt_w'(1);
            2'b01:   count_nxt_s = count_r - cnt_w'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Operand queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r]   <= in_a;
            mem_b_r[wr_ptr_r]   <= in_b;
            mem_tag_r[wr_ptr_r] <= in_tag;
        end
    end

    // State register, queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            wr_ptr_r <= ptr_w'(0);
            rd_ptr_r <= ptr_w'(0);
            count_r  <= cnt_w'(0);
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            in_ready <= (count_nxt_s != depth_c);
            busy     <= (state_nxt_s != IDLE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            end
        end
    end

    // Multiplier request: operands and tag latched from the queue head on issue
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_req   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            tag_r     <= '0;
            tmo_cnt_r <= tmo_w'(0);
        end else begin
            mul_req <= issue_s;
            if (issue_s) begin
                mul_a     <= mem_a_r[rd_ptr_r];
                mul_b     <= mem_b_r[rd_ptr_r];
                tag_r     <= mem_tag_r[rd_ptr_r];
                tmo_cnt_r <= tmo_w'(0);
            end else if (state_r == WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + tmo_w'(1);
            end
        end
    end

    // Result slot; a timed-out request returns zero and latches err until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_out   <= '0;
            res_tag   <= '0;
            err       <= 1'b0;
        end else begin
            if (pop_s) begin
                res_out <= timeout_s ? '0 : mul_out;
            end
            if (timeout_s) begin
                err <= 1'b1;
            end
            if (state_r == DONE) begin
                res_valid <= 1'b1;
                res_tag   <= tag_r;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_dispatch.sv
// Self-checking bench for float_mul_dispatch: the bench plays the multiplier and
// predicts results from pushed requests and the products it chose to return.
module tb_float_mul_dispatch;
    localparam int FW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_a;
    logic [FW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          mul_req;
    logic [FW-1:0] mul_a;
    logic [FW-1:0] mul_b;
    logic          mul_ack;
    logic [FW-1:0] mul_out;
    logic          res_valid;
    logic          res_ready;
    logic [FW-1:0] res_out;
    logic [TW-1:0] res_tag;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // multiplier model state and scoreboard
    int            lat_q[$];
    logic [FW-1:0] out_q[$];
    logic [FW-1:0] iss_a[$];
    logic [FW-1:0] iss_b[$];
    logic [FW-1:0] prov_out[$];
    logic [FW-1:0] exp_a[$];
    logic [FW-1:0] exp_b[$];
    logic [TW-1:0] exp_tag[$];
    logic [FW-1:0] got_out[$];
    logic [TW-1:0] got_tag[$];
    int            req_count  = 0;
    int            req_double = 0;
    int            req_cyc    = 0;
    int            ack_cyc    = 0;
    bit            force_ack  = 1'b0;
    bit            prev_req   = 1'b0;
    int            ack_cd     = -1;
    int            resp_lat;
    logic [FW-1:0] pend_out;

    float_mul_dispatch #(
        .float_width(FW), .tag_width(TW), .fifo_depth(DEPTH), .timeout_cycles(TMO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ack(mul_ack), .mul_out(mul_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_tag(res_tag), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier: answers each request after the next queued latency (-1 = never)
    initial begin
        mul_ack = 1'b0;
        mul_out = '0;
        forever begin
            @(negedge clk);
            mul_ack = 1'b0;
            mul_out = $urandom;
            if (rst === 1'b1) ack_cd = -1;
            if (ack_cd == 0) begin
                mul_ack = 1'b1; mul_out = pend_out; ack_cyc = cyc; ack_cd = -1;
            end else if (ack_cd > 0) begin
                ack_cd = ack_cd - 1;
            end
            if (force_ack) begin
                mul_ack = 1'b1; mul_out = 32'hDEAD_BEEF; force_ack = 1'b0;
            end
            if (mul_req === 1'b1) begin
                req_count = req_count + 1;
                if (prev_req) req_double = req_double + 1;
                req_cyc = cyc;
                iss_a.push_back(mul_a);
                iss_b.push_back(mul_b);
                resp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
                pend_out = (out_q.size() > 0) ? out_q.pop_front() : $urandom;
                if (resp_lat >= 0 && resp_lat < TMO) prov_out.push_back(pend_out);
                else prov_out.push_back('0);
                if (resp_lat == 0) begin
                    mul_ack = 1'b1; mul_out = pend_out; ack_cyc = cyc;
                end else if (resp_lat > 0) begin
                    ack_cd = resp_lat - 1;
                end
            end
            prev_req = (mul_req === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic clear_model();
        lat_q.delete(); out_q.delete(); iss_a.delete(); iss_b.delete();
        prov_out.delete(); exp_a.delete(); exp_b.delete(); exp_tag.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic push(input logic [FW-1:0] a, input logic [FW-1:0] b,
                        input logic [TW-1:0] t, input bit accepted);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        if (accepted) begin
            exp_a.push_back(a); exp_b.push_back(b); exp_tag.push_back(t);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic collect(input int n, input int budget, input bit rand_ready);
        got_out.delete(); got_tag.delete();
        for (int i = 0; i < budget && got_out.size() < n; i++) begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid === 1'b1 && res_ready) begin
                got_out.push_back(res_out); got_tag.push_back(res_tag);
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mul_req, res_valid, err, busy, in_ready} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00001", {mul_req, res_valid, err, busy, in_ready});
        end
        checks++;
        if (mul_a !== 32'h0 || mul_b !== 32'h0) begin
            errors++; $display("FAIL reset_mul_ops: got %h/%h expected 0/0", mul_a, mul_b);
        end
        checks++;
        if (res_out !== 32'h0 || res_tag !== 4'h0) begin
            errors++; $display("FAIL reset_result: got %h/%h expected 0/0", res_out, res_tag);
        end
    endtask

    task automatic test_single_op();
        int p, first, base;
        bit ok;
        do_reset();
        lat_q.push_back(3); out_q.push_back(32'h40C0_0000);
        base = req_count;
        push(32'h4000_0000, 32'h4040_0000, 4'd3, 1'b1);
        p = cyc;
        wait_valid(40, ok);
        first = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL single_valid: got none expected res_valid within 40 cycles"); end
        checks++;
        if (req_cyc - p !== 1) begin errors++; $display("FAIL single_req_latency: got %0d expected 1", req_cyc - p); end
        checks++;
        if (first - ack_cyc !== 2) begin errors++; $display("FAIL single_res_latency: got %0d expected 2", first - ack_cyc); end
        checks++;
        if (res_out !== 32'h40C0_0000 || res_tag !== 4'd3) begin
            errors++; $display("FAIL single_result: got %h tag %0d expected 40c00000 tag 3", res_out, res_tag);
        end
        checks++;
        if (iss_a.size() != 1 || iss_a[0] !== 32'h4000_0000 || iss_b[0] !== 32'h4040_0000) begin
            errors++; $display("FAIL single_operands: got %0d issues expected a=40000000 b=40400000", iss_a.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_out !== 32'h40C0_0000 || res_tag !== 4'd3 || req_count - base !== 1) begin
            errors++; $display("FAIL single_hold: got valid=%b out=%h reqs=%0d expected 1/40c00000/1", res_valid, res_out, req_count - base);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_drain: got valid=%b busy=%b expected 0/0", res_valid, busy);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== (i < DEPTH)) begin
                errors++; $display("FAIL fill_in_ready_%0d: got %b expected %b", i, in_ready, (i < DEPTH));
            end
            push(32'h3F80_0000 + 32'(i), 32'h4100_0000 + 32'(i), TW'(i), (i < DEPTH));
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got in_ready=%b expected 0", in_ready); end
        collect(DEPTH + 1, 5 * (TMO + 8), 1'b0);
        checks++;
        if (got_tag.size() != DEPTH) begin errors++; $display("FAIL fill_count: got %0d results expected %0d", got_tag.size(), DEPTH); end
        for (int i = 0; i < got_tag.size() && i < DEPTH; i++) begin
            checks++;
            if (got_tag[i] !== exp_tag[i] || got_out[i] !== 32'h0) begin
                errors++; $display("FAIL fill_result_%0d: got tag %0d out %h expected tag %0d out 0", i, got_tag[i], got_out[i], exp_tag[i]);
            end
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL fill_final: got err=%b busy=%b in_ready=%b expected 1/0/1", err, busy, in_ready);
        end
    endtask

    task automatic test_ordering();
        int base_double;
        do_reset();
        base_double = req_double;
        lat_q = '{1, 5, 2, 7};
        for (int i = 1; i <= 4; i++) push($urandom, $urandom, TW'(i), 1'b1);
        collect(4, 200, 1'b0);
        checks++;
        if (got_tag.size() != 4) begin errors++; $display("FAIL order_count: got %0d expected 4", got_tag.size()); end
        for (int i = 0; i < got_tag.size() && i < 4; i++) begin
            checks++;
            if (got_tag[i] !== exp_tag[i] || got_out[i] !== prov_out[i] || iss_a[i] !== exp_a[i] || iss_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL order_result_%0d: got tag %0d out %h expected tag %0d out %h", i, got_tag[i], got_out[i], exp_tag[i], prov_out[i]);
            end
        end
        checks++;
        if (req_double - base_double !== 0 || err !== 1'b0) begin
            errors++; $display("FAIL order_req_pulse: got %0d long pulses err=%b expected 0/0", req_double - base_double, err);
        end
    endtask

    task automatic test_timeout();
        int base, first;
        bit ok;
        do_reset();
        base = req_count;
        lat_q = '{-1, 2};
        push(32'h4000_0000, 32'h4000_0000, 4'd5, 1'b1);
        push(32'h4080_0000, 32'h3F00_0000, 4'd6, 1'b1);
        wait_valid(TMO + 20, ok);
        first = cyc;
        checks++;
        if (!ok || err !== 1'b1 || res_out !== 32'h0 || res_tag !== 4'd5) begin
            errors++; $display("FAIL timeout_result: got valid=%b err=%b out=%h tag=%0d expected 1/1/0/5", ok, err, res_out, res_tag);
        end
        checks++;
        if (first - req_cyc !== TMO + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", first - req_cyc, TMO + 1); end
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (res_out !== 32'h0 || res_tag !== 4'd5 || res_valid !== 1'b1 || req_count - base !== 1) begin
            errors++; $display("FAIL timeout_late_ack: got out=%h tag=%0d valid=%b reqs=%0d expected 0/5/1/1", res_out, res_tag, res_valid, req_count - base);
        end
        collect(2, 60, 1'b0);
        checks++;
        if (got_tag.size() != 2) begin errors++; $display("FAIL timeout_count: got %0d expected 2", got_tag.size()); end
        else begin
            checks++;
            if (got_tag[1] !== 4'd6 || got_out[1] !== prov_out[1] || err !== 1'b1) begin
                errors++; $display("FAIL timeout_next_op: got tag %0d out %h err=%b expected 6 %h 1", got_tag[1], got_out[1], err, prov_out[1]);
            end
        end
    endtask

    task automatic test_back_pressure();
        int base;
        bit ok;
        do_reset();
        base = req_count;
        lat_q = '{1, 1};
        push($urandom, $urandom, 4'd9, 1'b1);
        push($urandom, $urandom, 4'd10, 1'b1);
        wait_valid(30, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || res_valid !== 1'b1 || req_count - base !== 1 || res_tag !== 4'd9) begin
            errors++; $display("FAIL bp_stall: got valid=%b reqs=%0d tag=%0d expected 1/1/9", res_valid, req_count - base, res_tag);
        end
        collect(2, 60, 1'b0);
        checks++;
        if (got_tag.size() != 2 || req_count - base !== 2) begin
            errors++; $display("FAIL bp_count: got %0d results %0d reqs expected 2/2", got_tag.size(), req_count - base);
        end else begin
            checks++;
            if (got_tag[1] !== 4'd10 || got_out[1] !== prov_out[1] || got_out[0] !== prov_out[0]) begin
                errors++; $display("FAIL bp_result: got tag %0d out %h expected 10 %h", got_tag[1], got_out[1], prov_out[1]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        lat_q.push_back(-1);
        push($urandom, $urandom, 4'd7, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, busy, mul_req, err, in_ready} !== 5'b00001) begin
                errors++; $display("FAIL midwait_ctrl_%0d: got %b expected 00001", i, {res_valid, busy, mul_req, err, in_ready});
            end
        end
        checks++;
        if (res_out !== 32'h0 || res_tag !== 4'h0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
            errors++; $display("FAIL midwait_data: got out=%h tag=%h a=%h b=%h expected all 0", res_out, res_tag, mul_a, mul_b);
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            clear_model();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                lat_q.push_back($urandom_range(0, 12));
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready_%0d_%0d: got 0 expected 1", r, i); end
                push($urandom, $urandom, TW'($urandom_range(0, 15)), 1'b1);
            end
            collect(n, 300, 1'b1);
            checks++;
            if (got_tag.size() != n) begin errors++; $display("FAIL rand_count_%0d: got %0d expected %0d", r, got_tag.size(), n); end
            for (int i = 0; i < got_tag.size() && i < n; i++) begin
                checks++;
                if (got_tag[i] !== exp_tag[i] || got_out[i] !== prov_out[i] || iss_a[i] !== exp_a[i] || iss_b[i] !== exp_b[i]) begin
                    errors++; $display("FAIL rand_result_%0d_%0d: got tag %0d out %h expected tag %0d out %h", r, i, got_tag[i], got_out[i], exp_tag[i], prov_out[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; res_ready = 1'b0;
        test_reset();
        test_single_op();
        test_fill();
        test_ordering();
        test_timeout();
        test_back_pressure();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
